rom_arbiter: RTL
================

// Module: rom_arbiter
// PURPOSE
//  Shares the single fake ROM between two requesters: port 0 (instruction fetch, read-only) and port 1 (load/store unit, read/write).
//  Serialises all accesses, so ROM read-enable and write-enable are never high together.
//  Sequences each access as issue -> wait-for-done -> respond, with a timeout.
//  Sits between the fetch/mem stages and the rom block.
// PARAMETERS
//  ADDR_W       32  address width (COMMON_WIDTH)
//  DATA_W       32  data width (COMMON_WIDTH)
//  TIMEOUT_CYC  16  max WAIT cycles before error response; legal range 1..255
// PORTS
//  clk           in   1       clock, all state on posedge
//  rst           in   1       async active-high reset
//  p0_req        in   1       port0 request; held until p0_ack
//  p0_addr       in   ADDR_W  port0 byte address
//  p0_byte_num   in   3       port0 byte count, 1..4
//  p0_ack        out  1       1-cycle completion pulse
//  p0_err        out  1       with p0_ack: access timed out
//  p0_rdata      out  DATA_W  read data; valid with p0_ack, held until next p0_ack
//  p1_req        in   1       port1 request; held until p1_ack
//  p1_we         in   1       1 = write, 0 = read
//  p1_addr       in   ADDR_W  port1 byte address
//  p1_wdata      in   DATA_W  port1 write data
//  p1_byte_num   in   3       port1 byte count, 1..4
//  p1_ack        out  1       1-cycle completion pulse
//  p1_err        out  1       with p1_ack: access timed out
//  p1_rdata      out  DATA_W  read data (0 for writes); valid with p1_ack, held until next p1_ack
//  rom_rd_en     out  1       to ROM read enable
//  rom_wr_en     out  1       to ROM write enable
//  rom_addr      out  ADDR_W  to ROM, shared by read and write
//  rom_wdata     out  DATA_W  to ROM write data
//  rom_byte_num  out  3       to ROM byte count
//  rom_rdata     in   DATA_W  from ROM read data
//  rom_done      in   1       from ROM; may be stuck high
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; timeout counter 0; RR pointer = port1-last, so port0 wins first.
//  - Reset mid-access abandons the access: enables drop immediately (async) and no ack is produced.
//  - Requester rules:
//    - req and its fields are stable from assertion through the ack cycle.
//    - req still high in the cycle after ack is treated as a new request.
//  - FSM:
//    - IDLE: if any req, pick winner and latch its fields into rom_* regs; go to ISSUE.
//      - rom_byte_num clamp: 0 -> 1, >4 -> 4.
//    - ISSUE (1 cycle): exactly one of rom_rd_en / rom_wr_en = 1 (port0 is always a read); go to WAIT.
//    - WAIT: enables 0; rom_addr, rom_wdata and rom_byte_num held.
//      - rom_done is sampled only in WAIT, so a stale done left high from the previous access is tolerated.
//      - done=1: latch rom_rdata (reads only); go to RESP.
//      - Otherwise count up; at TIMEOUT_CYC go to RESP with err=1 and rdata=0.
//    - RESP (1 cycle): winner's ack=1 (and err if timed out); go to IDLE.
//  - Minimum latency: req seen at edge t0 -> rom en high t0..t1 -> ack high t2..t3, i.e. 3 cycles, at most 1 access per 4 cycles.
//  - Requests arriving while busy wait in their hold state; neither is dropped.
//  - Both req high in IDLE: the arbitration policy below decides.
//  - Invariant: rom_rd_en & rom_wr_en == 0 in every cycle.
//  - The non-winning ack and err stay 0.
// CONFIGURATION
//  ROM_ARB_RR_EN defined:
//    - Round-robin; the most recently granted port has lower priority.
//    - The pointer updates on each RESP.
//  ROM_ARB_RR_EN undefined:
//    - Fixed priority, port1 over port0; no RR pointer state.
//    - Port0 can starve while p1_req stays high.
// TESTING
//  1 p0 read addr=0x8 byte_num=4, ROM done=1 -> rom_rd_en pulses 1 cycle with addr 0x8; p0_ack 3 cycles after req; p0_rdata=ROM data.
//  2 p1 write addr=0x4 data=0xDEADBEEF byte_num=4, then p1 read same addr -> read returns 0xDEADBEEF; rom_wr_en and rom_rd_en never overlap.
//  3 p0 and p1 req on same edge, held high 8 accesses:
//    - RR build: grants alternate, starting p0.
//    - Fixed build: p1 gets all 8.
//  4 rom_done held 0 -> after TIMEOUT_CYC WAIT cycles, ack=1 err=1 rdata=0; the next access completes normally.
//  5 rst asserted during WAIT of a p1 write -> enables 0 immediately; no p1_ack; first post-reset request is served normally.
//  6 p1 byte_num=0 and byte_num=7 -> rom_byte_num=1 and 4 respectively.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Bus bundle between the two ROM requesters (fetch, load/store), the
// arbiter and the fake ROM. The slave modport is the arbiter's view; the
// master modport is the view of whatever drives requests and plays the ROM.
interface rom_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // port 0: instruction fetch, read-only
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic [2:0]        p0_byte_num;
  logic              p0_ack;
  logic              p0_err;
  logic [DATA_W-1:0] p0_rdata;

  // port 1: load/store unit, read/write
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [2:0]        p1_byte_num;
  logic              p1_ack;
  logic              p1_err;
  logic [DATA_W-1:0] p1_rdata;

  // shared ROM side
  logic              rom_rd_en;
  logic              rom_wr_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata;
  logic [2:0]        rom_byte_num;
  logic [DATA_W-1:0] rom_rdata;
  logic              rom_done;

  modport slave (
    input  p0_req, p0_addr, p0_byte_num,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_byte_num,
    output p1_ack, p1_err, p1_rdata,
    output rom_rd_en, rom_wr_en, rom_addr, rom_wdata, rom_byte_num,
    input  rom_rdata, rom_done
  );

  modport master (
    output p0_req, p0_addr, p0_byte_num,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_byte_num,
    input  p1_ack, p1_err, p1_rdata,
    input  rom_rd_en, rom_wr_en, rom_addr, rom_wdata, rom_byte_num,
    output rom_rdata, rom_done
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: serialises port 0 (fetch, reads only) and port 1 (load/store)
// onto the single fake ROM. Each access runs IDLE -> ISSUE -> WAIT -> RESP;
// WAIT gives up after TIMEOUT_CYC cycles and answers with err=1, rdata=0.
// Build option: define ROM_ARB_RR_EN for round-robin arbitration; without it
// port 1 always wins over port 0.
module rom_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input logic         clk,
  input logic         rst,
  rom_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYC - 1);

  state_t            state;
  state_t            state_nxt;
  logic              any_req;
  logic              pick;
  logic              grant;
  logic              is_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        bn_q;
  logic [7:0]        tcnt;
  logic              err_q;
  logic [DATA_W-1:0] p0_rdata_q;
  logic [DATA_W-1:0] p1_rdata_q;

  // The ROM only understands 1..4 bytes; out-of-range counts are pulled in.
  function automatic logic [2:0] clamp_bn(input logic [2:0] n);
    if (n == 3'd0) return 3'd1;
    if (n > 3'd4)  return 3'd4;
    return n;
  endfunction

  assign any_req = bus.p0_req | bus.p1_req;

`ifdef ROM_ARB_RR_EN
  logic last_q;

  // Remember which port was served last; reset makes port 0 win first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 last_q <= 1'b1;
    else if (state == RESP)  last_q <= grant;
  end

  // On a tie the port that was not served most recently wins.
  always_comb begin
    pick = bus.p1_req;
    if (bus.p0_req && bus.p1_req) pick = ~last_q;
  end
`else
  assign pick = bus.p1_req;
`endif

  // State register; async reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and the per-state strobes (enables only in ISSUE, ack only in RESP).
  always_comb begin
    state_nxt         = state;
    bus.rom_rd_en     = 1'b0;
    bus.rom_wr_en     = 1'b0;
    bus.p0_ack        = 1'b0;
    bus.p1_ack        = 1'b0;
    bus.p0_err        = 1'b0;
    bus.p1_err        = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.rom_rd_en = ~is_wr;
        bus.rom_wr_en = is_wr;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (bus.rom_done || (tcnt == TLAST)) state_nxt = RESP;
      end
      RESP: begin
        bus.p0_ack = ~grant;
        bus.p1_ack = grant;
        bus.p0_err = ~grant & err_q;
        bus.p1_err = grant & err_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's fields on grant, then capture the response in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= 1'b0;
      is_wr      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bn_q       <= '0;
      tcnt       <= '0;
      err_q      <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            tcnt  <= '0;
            err_q <= 1'b0;
            if (pick) begin
              is_wr   <= bus.p1_we;
              addr_q  <= bus.p1_addr;
              wdata_q <= bus.p1_wdata;
              bn_q    <= clamp_bn(bus.p1_byte_num);
            end else begin
              is_wr   <= 1'b0;
              addr_q  <= bus.p0_addr;
              wdata_q <= '0;
              bn_q    <= clamp_bn(bus.p0_byte_num);
            end
          end
        end
        WAIT: begin
          if (bus.rom_done) begin
            if (grant) p1_rdata_q <= is_wr ? '0 : bus.rom_rdata;
            else       p0_rdata_q <= bus.rom_rdata;
          end else if (tcnt == TLAST) begin
            err_q <= 1'b1;
            if (grant) p1_rdata_q <= '0;
            else       p0_rdata_q <= '0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr     = addr_q;
  assign bus.rom_wdata    = wdata_q;
  assign bus.rom_byte_num = bn_q;
  assign bus.p0_rdata     = p0_rdata_q;
  assign bus.p1_rdata     = p1_rdata_q;

endmodule
